// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per cycle,
// with results presented in register-file write-port form (result, rd_out, wb_we).
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            wb_we,
    output logic [1:0]      dbg_state
);

    // Handshake: start is sampled only in IDLE or DONE (and only without kill); the core
    // holds the request while busy is high. done pulses for one cycle with result/rd_out valid.
    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [2:0]        f3_q, f3_d;
    logic [4:0]        rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              accept;
    logic              last_step;
    logic              a_signed, b_signed, sign_a, sign_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   special_val;

    logic [XLEN:0]     mul_addend, mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     rem_sh, rem_diff;
    logic              q_bit;
    logic [XLEN-1:0]   rem_new;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] step_acc;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   div_val, div_fix, final_val;

    assign accept    = start && !kill && (state_q == S_IDLE || state_q == S_DONE);
    assign last_step = (cnt_q == CNT_W'(XLEN - 1));

    // Operand decode at accept: signedness, magnitudes and the no-iteration special cases.
    always_comb begin
        a_signed = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
        b_signed = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
        sign_a   = a_signed && op_a[XLEN-1];
        sign_b   = b_signed && op_b[XLEN-1];
        mag_a    = sign_a ? -op_a : op_a;
        mag_b    = sign_b ? -op_b : op_b;
        div_zero = (op_b == '0);
        div_ovf  = ((funct3 == 3'd4) || (funct3 == 3'd6))
                   && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        special  = funct3[2] && (div_zero || div_ovf);
        if (div_zero) begin
            special_val = funct3[1] ? op_a : '1;
        end else begin
            special_val = funct3[1] ? '0 : op_a;
        end
    end

    // One iteration step for both datapaths; the op latched at accept picks which is used.
    always_comb begin
        mul_addend = acc_q[0] ? {1'b0, opnd_q} : '0;
        mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + mul_addend;
        mul_next   = {mul_sum, acc_q[XLEN-1:1]};

        rem_sh     = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        rem_diff   = rem_sh - {1'b0, opnd_q};
        q_bit      = !rem_diff[XLEN];
        rem_new    = q_bit ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        div_next   = {rem_new, acc_q[XLEN-2:0], q_bit};

        step_acc   = f3_q[2] ? div_next : mul_next;
    end

    // Sign fix-up of the final step's value, selected into the write-back word.
    always_comb begin
        prod_fix = neg_q ? -step_acc : step_acc;
        div_val  = f3_q[1] ? step_acc[2*XLEN-1:XLEN] : step_acc[XLEN-1:0];
        div_fix  = neg_q ? -div_val : div_val;
        if (f3_q[2]) begin
            final_val = div_fix;
        end else if (f3_q[1:0] == 2'd0) begin
            final_val = prod_fix[XLEN-1:0];
        end else begin
            final_val = prod_fix[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        f3_d     = f3_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        result_d = result_q;
        if (accept) begin
            f3_d   = funct3;
            rd_d   = rd_in;
            cnt_d  = '0;
            neg_d  = (funct3 == 3'd6) ? sign_a : (sign_a ^ sign_b);
            opnd_d = funct3[2] ? mag_b : mag_a;
            acc_d  = {{XLEN{1'b0}}, (funct3[2] ? mag_a : mag_b)};
            if (special) begin
                result_d = special_val;
            end
        end else if (state_q == S_BUSY && !kill) begin
            acc_d = step_acc;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_step) begin
                result_d = final_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f3_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            f3_q     <= f3_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // kill overrides everything, including a start presented in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = special ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else if (last_step) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else if (accept) begin
                    state_d = special ? S_DONE : S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == S_BUSY);
        done      = (state_q == S_DONE);
        wb_we     = (state_q == S_DONE) && (rd_q != 5'd0);
        dbg_state = state_q;
    end

    assign result = result_q;
    assign rd_out = rd_q;

endmodule
